// File: rtl/seg_pkg.sv
// seg_pkg: seven-segment encoding shared by the display driver and the scan receiver.
// Patterns are {g,f,e,d,c,b,a}, active-high.
package seg_pkg;

    localparam int DIGITS = 8;

    localparam logic [6:0] SEG_0 = 7'h3F;
    localparam logic [6:0] SEG_1 = 7'h06;
    localparam logic [6:0] SEG_2 = 7'h5B;
    localparam logic [6:0] SEG_3 = 7'h4F;
    localparam logic [6:0] SEG_4 = 7'h66;
    localparam logic [6:0] SEG_5 = 7'h6D;
    localparam logic [6:0] SEG_6 = 7'h7D;
    localparam logic [6:0] SEG_7 = 7'h07;
    localparam logic [6:0] SEG_8 = 7'h7F;
    localparam logic [6:0] SEG_9 = 7'h6F;
    localparam logic [6:0] SEG_A = 7'h77;
    localparam logic [6:0] SEG_B = 7'h7C;
    localparam logic [6:0] SEG_C = 7'h39;
    localparam logic [6:0] SEG_D = 7'h5E;
    localparam logic [6:0] SEG_E = 7'h79;
    localparam logic [6:0] SEG_F = 7'h71;

    typedef enum logic {SYNC, COLLECT} state_t;

endpackage

// File: rtl/seg_hex_decode.sv
// seg_hex_decode: maps an active-high {g..a} pattern back to its hex nibble.
// o_valid is low for any pattern outside the sixteen hex glyphs.
module seg_hex_decode
    import seg_pkg::*;
(
    input  logic [6:0] i_seg,
    output logic [3:0] o_nib,
    output logic       o_valid
);

    // Pattern lookup; unknown glyphs flag invalid and decode as 0.
    always_comb begin
        o_nib   = 4'h0;
        o_valid = 1'b1;
        case (i_seg)
            SEG_0:   o_nib = 4'h0;
            SEG_1:   o_nib = 4'h1;
            SEG_2:   o_nib = 4'h2;
            SEG_3:   o_nib = 4'h3;
            SEG_4:   o_nib = 4'h4;
            SEG_5:   o_nib = 4'h5;
            SEG_6:   o_nib = 4'h6;
            SEG_7:   o_nib = 4'h7;
            SEG_8:   o_nib = 4'h8;
            SEG_9:   o_nib = 4'h9;
            SEG_A:   o_nib = 4'hA;
            SEG_B:   o_nib = 4'hB;
            SEG_C:   o_nib = 4'hC;
            SEG_D:   o_nib = 4'hD;
            SEG_E:   o_nib = 4'hE;
            SEG_F:   o_nib = 4'hF;
            default: o_valid = 1'b0;
        endcase
    end

endmodule

// File: rtl/seg_scan_rx.sv
// seg_scan_rx: loopback monitor for the 8-digit multiplexed seven-segment scan.
// Reconstructs the displayed 32-bit word and pulses data_valid once per clean,
// in-order frame (digits 0..7); frame_err pulses when a frame is discarded.
// Optional macro SEG_DP_CAPTURE_EN adds capture of the decimal points on dp_out.
module seg_scan_rx
    import seg_pkg::*;
#(
    parameter int STABLE_CYCLES  = 4,
    parameter bit SEG_ACTIVE_LOW = 1'b1
)
(
    input  logic        clk,
    input  logic        rst,
    input  logic [2:0]  which,
    input  logic [7:0]  seg,
    output logic [31:0] data_out,
    output logic        data_valid,
    output logic        frame_err,
    output logic        changed
`ifdef SEG_DP_CAPTURE_EN
    ,
    output logic [7:0]  dp_out
`endif
);

    localparam logic [7:0] STAB_TARGET = 8'(STABLE_CYCLES);

    logic [2:0]  r_which_q;
    logic [7:0]  r_seg_q;
    logic [7:0]  r_stab;
    state_t      r_state;
    logic [2:0]  r_expect;
    logic [31:0] r_shadow;
    logic        r_bad;
    logic [31:0] r_data_out;
    logic        r_valid;
    logic        r_ferr;
    logic        r_changed;

    logic        w_accept;
    logic [6:0]  w_seg7;
    logic [3:0]  w_nib;
    logic        w_dec_valid;
    logic        w_in_order;
    state_t      w_state_nxt;
    logic [2:0]  w_expect_nxt;
    logic [31:0] w_shadow_nxt;
    logic        w_bad_nxt;
    logic [31:0] w_word_nxt;
    logic        w_valid_nxt;
    logic        w_ferr_nxt;
    logic        w_changed_nxt;

`ifdef SEG_DP_CAPTURE_EN
    logic [7:0]  r_dp_sh;
    logic [7:0]  r_dp_out;
    logic [7:0]  w_dp_sh_nxt;
    logic [7:0]  w_dp_out_nxt;
    logic        w_dp_n;

    assign w_dp_n = r_seg_q[7] ^ SEG_ACTIVE_LOW;
    assign dp_out = r_dp_out;
`endif

    // Sample the scan once and count how long the current sample has held.
    // The count tracks the age of which_q/seg_q so an accept lands exactly
    // STABLE_CYCLES cycles after the inputs settle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_which_q <= 3'd0;
            r_seg_q   <= 8'd0;
            r_stab    <= 8'd0;
        end else begin
            r_which_q <= which;
            r_seg_q   <= seg;
            if ({which, seg} != {r_which_q, r_seg_q})
                r_stab <= 8'd1;
            else if (r_stab != 8'hFF)
                r_stab <= r_stab + 8'd1;
        end
    end

    assign w_accept = (r_stab == STAB_TARGET);
    assign w_seg7   = SEG_ACTIVE_LOW ? ~r_seg_q[6:0] : r_seg_q[6:0];

    seg_hex_decode u_dec (
        .i_seg   (w_seg7),
        .o_nib   (w_nib),
        .o_valid (w_dec_valid)
    );

    // Frame FSM: next state, shadow word assembly and frame-end outputs.
    always_comb begin
        w_state_nxt   = r_state;
        w_expect_nxt  = r_expect;
        w_shadow_nxt  = r_shadow;
        w_bad_nxt     = r_bad;
        w_word_nxt    = r_data_out;
        w_valid_nxt   = 1'b0;
        w_ferr_nxt    = 1'b0;
        w_changed_nxt = r_changed;
        w_in_order    = (r_state == COLLECT) && (r_which_q == r_expect);
`ifdef SEG_DP_CAPTURE_EN
        w_dp_sh_nxt   = r_dp_sh;
        w_dp_out_nxt  = r_dp_out;
`endif
        if (w_accept) begin
            // Out-of-order digit while collecting: drop the partial frame.
            if ((r_state == COLLECT) && !w_in_order) begin
                w_ferr_nxt   = 1'b1;
                w_shadow_nxt = 32'd0;
                w_state_nxt  = SYNC;
`ifdef SEG_DP_CAPTURE_EN
                w_dp_sh_nxt  = 8'd0;
`endif
            end
            // Digit 0 always (re)starts a frame; otherwise only in-order digits store.
            if (w_in_order || (r_which_q == 3'd0)) begin
                for (int i = 0; i < DIGITS; i++) begin
                    if (r_which_q == 3'(i)) begin
                        w_shadow_nxt[4*i +: 4] = w_nib;
`ifdef SEG_DP_CAPTURE_EN
                        w_dp_sh_nxt[i] = w_dp_n;
`endif
                    end
                end
                w_bad_nxt    = ((r_which_q == 3'd0) ? 1'b0 : r_bad) | ~w_dec_valid;
                w_expect_nxt = r_which_q + 3'd1;
                w_state_nxt  = COLLECT;
                if (r_which_q == 3'd7) begin
                    if (w_bad_nxt) begin
                        w_ferr_nxt = 1'b1;
                    end else begin
                        w_valid_nxt   = 1'b1;
                        w_word_nxt    = w_shadow_nxt;
                        w_changed_nxt = (w_shadow_nxt != r_data_out);
`ifdef SEG_DP_CAPTURE_EN
                        w_changed_nxt = w_changed_nxt | (w_dp_sh_nxt != r_dp_out);
                        w_dp_out_nxt  = w_dp_sh_nxt;
`endif
                    end
                end
            end
        end
    end

    // Frame FSM and output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= SYNC;
            r_expect   <= 3'd0;
            r_shadow   <= 32'd0;
            r_bad      <= 1'b0;
            r_data_out <= 32'd0;
            r_valid    <= 1'b0;
            r_ferr     <= 1'b0;
            r_changed  <= 1'b0;
`ifdef SEG_DP_CAPTURE_EN
            r_dp_sh    <= 8'd0;
            r_dp_out   <= 8'd0;
`endif
        end else begin
            r_state    <= w_state_nxt;
            r_expect   <= w_expect_nxt;
            r_shadow   <= w_shadow_nxt;
            r_bad      <= w_bad_nxt;
            r_data_out <= w_word_nxt;
            r_valid    <= w_valid_nxt;
            r_ferr     <= w_ferr_nxt;
            r_changed  <= w_changed_nxt;
`ifdef SEG_DP_CAPTURE_EN
            r_dp_sh    <= w_dp_sh_nxt;
            r_dp_out   <= w_dp_out_nxt;
`endif
        end
    end

    assign data_out   = r_data_out;
    assign data_valid = r_valid;
    assign frame_err  = r_ferr;
    assign changed    = r_changed;

endmodule

// File: tb/tb_seg_scan_rx.sv
// tb_seg_scan_rx: scoreboard bench for seg_scan_rx. Each driven dwell is run
// through a frame-level reference model; expected data_valid/frame_err events
// (with their arrival cycle) are queued and matched against the DUT pulses.
module tb_seg_scan_rx;

    localparam int STAB    = 4;
    localparam bit ACT_LOW = 1'b1;
`ifdef SEG_DP_CAPTURE_EN
    localparam bit DP_EN = 1'b1;
`else
    localparam bit DP_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [2:0]  which = 3'd7;
    logic [7:0]  seg = 8'hFF;
    logic [31:0] data_out;
    logic        data_valid;
    logic        frame_err;
    logic        changed;
`ifdef SEG_DP_CAPTURE_EN
    logic [7:0]  dp_out;
`endif

    seg_scan_rx #(
        .STABLE_CYCLES  (STAB),
        .SEG_ACTIVE_LOW (ACT_LOW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .which      (which),
        .seg        (seg),
        .data_out   (data_out),
        .data_valid (data_valid),
        .frame_err  (frame_err),
        .changed    (changed)
`ifdef SEG_DP_CAPTURE_EN
        ,
        .dp_out     (dp_out)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    // Hex glyphs {g..a}, active-high.
    logic [6:0] pat [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                             7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
    localparam logic [7:0] IDLE = ACT_LOW ? 8'hFF : 8'h00;

    typedef struct {
        bit          is_err;
        logic [31:0] word;
        logic [7:0]  dp;
        bit          chg;
        int          at;
    } ev_t;
    ev_t q[$];
    ev_t m_ev;

    // Reference model state.
    bit          m_sync;
    int          m_exp;
    logic [31:0] m_shadow;
    logic [31:0] m_word;
    logic [7:0]  m_dpsh;
    logic [7:0]  m_dp;
    bit          m_bad;
    logic [10:0] m_prev;

    function automatic logic [7:0] enc(input logic [3:0] nib, input logic dp);
        logic [7:0] s;
        s = {dp, pat[nib]};
        return ACT_LOW ? ~s : s;
    endfunction

    task automatic push_ev(input bit is_err, input bit chg, input int at);
        ev_t e;
        e.is_err = is_err;
        e.word   = m_word;
        e.dp     = m_dp;
        e.chg    = chg;
        e.at     = at;
        q.push_back(e);
    endtask

    task automatic model_reset();
        m_sync = 1'b1; m_exp = 0; m_shadow = '0; m_word = '0;
        m_dpsh = '0; m_dp = '0; m_bad = 1'b0;
    endtask

    // One accepted digit; n is the active-high segment byte.
    task automatic model_accept(input int idx, input logic [7:0] n, input int at);
        logic [3:0] nib;
        bit ok;
        bit chg;
        nib = 4'h0;
        ok  = 1'b0;
        for (int v = 0; v < 16; v++) begin
            if (pat[v] == n[6:0]) begin
                nib = v[3:0];
                ok  = 1'b1;
            end
        end
        if (!m_sync && idx != m_exp) begin
            push_ev(1'b1, 1'b0, at);
            m_shadow = '0;
            m_dpsh   = '0;
            m_sync   = 1'b1;
        end
        if ((!m_sync && idx == m_exp) || idx == 0) begin
            m_shadow[4*idx +: 4] = nib;
            m_dpsh[idx] = n[7];
            m_bad  = (idx == 0) ? !ok : (m_bad || !ok);
            m_sync = 1'b0;
            m_exp  = (idx + 1) % 8;
            if (idx == 7) begin
                if (m_bad) begin
                    push_ev(1'b1, 1'b0, at);
                end else begin
                    chg    = (m_shadow != m_word) || (DP_EN && (m_dpsh != m_dp));
                    m_word = m_shadow;
                    m_dp   = m_dpsh;
                    push_ev(1'b0, chg, at);
                end
            end
        end
    endtask

    // Hold one digit on the scan for len cycles.
    task automatic dwell(input int idx, input logic [7:0] raw, input int len);
        logic [7:0] n;
        @(posedge clk);
        #1;
        which = 3'(idx);
        seg   = raw;
        n = ACT_LOW ? ~raw : raw;
        if (({3'(idx), raw} != m_prev) && (len >= STAB))
            model_accept(idx, n, cyc + STAB + 1);
        m_prev = {3'(idx), raw};
        repeat (len - 1) @(posedge clk);
    endtask

    // Full in-order scan; bad_digit (0..7) is shown blank, short_digit gets short_len.
    task automatic scan(input logic [31:0] w, input logic [7:0] dpm, input int len,
                        input int bad_digit, input int short_digit, input int short_len);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) begin
            r = enc(w[4*i +: 4], dpm[i]);
            if (i == bad_digit) r = IDLE;
            dwell(i, r, (i == short_digit) ? short_len : len);
        end
    endtask

    task automatic do_reset();
        @(posedge clk);
        #3;
        which = 3'd7;
        seg   = IDLE;
        rst   = 1'b0;
        #1;
        check("rst_data_out", data_out, 32'd0);
        check("rst_data_valid", data_valid, 1'b0);
        check("rst_frame_err", frame_err, 1'b0);
        check("rst_changed", changed, 1'b0);
`ifdef SEG_DP_CAPTURE_EN
        check("rst_dp_out", dp_out, 8'd0);
`endif
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        model_reset();
        m_prev = {3'd7, IDLE};
        repeat (6) @(posedge clk);
    endtask

    // Scoreboard: match every DUT pulse against the queued expectation.
    always @(negedge clk) begin
        if (rst) begin
            if (data_valid || frame_err) begin
                check("pulse_exclusive", data_valid & frame_err, 1'b0);
                if (q.size() == 0) begin
                    check("unexpected_pulse", {data_valid, frame_err}, 2'b00);
                end else begin
                    m_ev = q.pop_front();
                    check("event_kind_err", frame_err, m_ev.is_err);
                    check("event_cycle", cyc, m_ev.at);
                    if (!m_ev.is_err) begin
                        check("data_out", data_out, m_ev.word);
                        check("changed", changed, m_ev.chg);
`ifdef SEG_DP_CAPTURE_EN
                        check("dp_out", dp_out, m_ev.dp);
`endif
                    end
                end
            end
            if (q.size() > 0 && cyc > q[0].at) begin
                check("missing_event", cyc, q[0].at);
                void'(q.pop_front());
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
        $fatal(1, "timeout");
    end

    initial begin
        model_reset();
        m_prev = {3'd7, IDLE};
        do_reset();

        // Clean frame, then the same word again.
        scan(32'h12345678, 8'h00, 4, -1, -1, 0);
        scan(32'h12345678, 8'h00, 4, -1, -1, 0);

        // Undecodable digit 3: frame discarded, word held.
        scan(32'h12345678, 8'h00, 4, 3, -1, 0);
        repeat (3) @(posedge clk);
        #1;
        check("hold_after_bad", data_out, 32'h12345678);
        check("changed_hold", changed, 1'b0);
        scan(32'h0000ABCD, 8'h00, 4, -1, -1, 0);

        // Out-of-order scan 0,1,2,4 then the rest of the digits, then a full frame.
        dwell(0, enc(4'h1, 1'b0), 4);
        dwell(1, enc(4'h2, 1'b0), 4);
        dwell(2, enc(4'h3, 1'b0), 4);
        dwell(4, enc(4'h5, 1'b0), 4);
        dwell(5, enc(4'h6, 1'b0), 4);
        dwell(6, enc(4'h7, 1'b0), 4);
        dwell(7, enc(4'h8, 1'b0), 4);
        scan(32'hCAFEF00D, 8'h00, 4, -1, -1, 0);

        // All dwells too short: nothing accepted.
        scan(32'h87654321, 8'h00, 3, -1, -1, 0);
        scan(32'h0F1E2D3C, 8'h00, 5, -1, -1, 0);

        // Digit 5 too short: order breaks at digit 6.
        scan(32'h13579BDF, 8'h00, 4, -1, 5, 2);
        scan(32'h2468ACE0, 8'h00, 4, -1, -1, 0);

        // Reset mid-frame, then a partial scan before the first full frame.
        dwell(0, enc(4'h0, 1'b0), 4);
        dwell(1, enc(4'h0, 1'b0), 4);
        dwell(2, enc(4'h0, 1'b0), 4);
        do_reset();
        dwell(4, enc(4'hE, 1'b0), 4);
        dwell(5, enc(4'hD, 1'b0), 4);
        dwell(6, enc(4'hC, 1'b0), 4);
        dwell(7, enc(4'hB, 1'b0), 4);
        scan(32'h9ABCDEF0, 8'h00, 4, -1, -1, 0);

`ifdef SEG_DP_CAPTURE_EN
        // Decimal points on digits 0 and 7, then a dp-only change.
        scan(32'hDEADBEEF, 8'h81, 4, -1, -1, 0);
        scan(32'hDEADBEEF, 8'h01, 4, -1, -1, 0);
`endif

        repeat (12) @(posedge clk);
        #1;
        check("queue_drained", q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
